// File: rtl/wb_pipe.sv
// Write-back stage: a 2-entry skid buffer between MEM and the register file.
// It formats load data at push time and counts retired entries.
module wb_pipe #(
    parameter int D_SIZE        = 32,
    parameter int ADDR_LINE_REG = 5,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_f_mem,
    output logic                     ready_f_wb_to_mem,
    input  logic                     reg_write_f_mem,
    input  logic                     mem_to_reg_f_mem,
    input  logic [D_SIZE-1:0]        alu_out_f_mem_2_wb,
    input  logic [31:0]              mem_rdata_f_mem_2_wb,
    input  logic [1:0]               ld_size_f_mem,
    input  logic                     ld_unsigned_f_mem,
    input  logic [1:0]               ld_offset_f_mem,
    input  logic [ADDR_LINE_REG-1:0] alu_add_f_mem_2_wb,
    input  logic                     flush_f_ctrl,
    input  logic                     rf_ready_f_id,
    output logic                     wb_valid_f_wb_id,
    output logic                     reg_we_f_wb_id,
    output logic [D_SIZE-1:0]        reg_data_f_wb_id,
    output logic [ADDR_LINE_REG-1:0] reg_addr_f_wb_id,
    output logic                     mem_to_reg_f_wb_to_id,
    output logic [CNT_W-1:0]         retire_cnt
);

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_to_reg;
        logic [D_SIZE-1:0]        data;
        logic [ADDR_LINE_REG-1:0] addr;
    } entry_t;

    entry_t           buf_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic             push, pop;
    entry_t           push_entry;
    entry_t           head;
    logic [31:0]      byte_shift, half_shift;
    logic             sign;
    logic [D_SIZE-1:0] load_data;

    // Load formatting: fill with the extension bit, then overlay the selected field.
    always_comb begin
        byte_shift = mem_rdata_f_mem_2_wb >> {ld_offset_f_mem, 3'b000};
        half_shift = mem_rdata_f_mem_2_wb >> {ld_offset_f_mem[1], 4'b0000};
        sign       = 1'b0;
        load_data  = '0;
        unique case (ld_size_f_mem)
            2'b00: begin
                sign            = !ld_unsigned_f_mem && byte_shift[7];
                load_data       = {D_SIZE{sign}};
                load_data[7:0]  = byte_shift[7:0];
            end
            2'b01: begin
                sign            = !ld_unsigned_f_mem && half_shift[15];
                load_data       = {D_SIZE{sign}};
                load_data[15:0] = half_shift[15:0];
            end
            default: begin
                sign            = !ld_unsigned_f_mem && mem_rdata_f_mem_2_wb[31];
                load_data       = {D_SIZE{sign}};
                load_data[31:0] = mem_rdata_f_mem_2_wb;
            end
        endcase
    end

    always_comb begin
        push_entry.reg_write  = reg_write_f_mem;
        push_entry.mem_to_reg = mem_to_reg_f_mem;
        push_entry.data       = mem_to_reg_f_mem ? load_data : alu_out_f_mem_2_wb;
        push_entry.addr       = alu_add_f_mem_2_wb;
    end

    assign head = buf_q[rd_ptr_q];

    always_comb begin
        push     = valid_f_mem && ready_q && !flush_f_ctrl;
        pop      = (count_q != 2'd0) && rf_ready_f_id && !flush_f_ctrl;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        retire_d = retire_q;
        if (flush_f_ctrl) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = !wr_ptr_q;
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
                retire_d = retire_q + CNT_W'(1);
            end
            if (push && !pop) count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
            retire_q <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ready_q  <= ready_d;
            retire_q <= retire_d;
            if (push) buf_q[wr_ptr_q] <= push_entry;
        end
    end

    // Outputs are gated so an empty buffer presents all zeros.
    always_comb begin
        wb_valid_f_wb_id      = (count_q != 2'd0);
        reg_we_f_wb_id        = wb_valid_f_wb_id && head.reg_write
                                && (head.addr != '0) && rf_ready_f_id;
        reg_data_f_wb_id      = wb_valid_f_wb_id ? head.data : '0;
        reg_addr_f_wb_id      = wb_valid_f_wb_id ? head.addr : '0;
        mem_to_reg_f_wb_to_id = wb_valid_f_wb_id && head.mem_to_reg;
    end

    assign ready_f_wb_to_mem = ready_q;
    assign retire_cnt        = retire_q;

endmodule

// File: tb/tb_wb_pipe.sv
// Scoreboard bench for wb_pipe: stimulus queues expected write-backs, a
// negedge monitor compares them as the DUT retires entries.
module tb_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_f_mem;
    logic        ready_f_wb_to_mem;
    logic        reg_write_f_mem;
    logic        mem_to_reg_f_mem;
    logic [31:0] alu_out_f_mem_2_wb;
    logic [31:0] mem_rdata_f_mem_2_wb;
    logic [1:0]  ld_size_f_mem;
    logic        ld_unsigned_f_mem;
    logic [1:0]  ld_offset_f_mem;
    logic [4:0]  alu_add_f_mem_2_wb;
    logic        flush_f_ctrl;
    logic        rf_ready_f_id;
    logic        wb_valid_f_wb_id;
    logic        reg_we_f_wb_id;
    logic [31:0] reg_data_f_wb_id;
    logic [4:0]  reg_addr_f_wb_id;
    logic        mem_to_reg_f_wb_to_id;
    logic [3:0]  retire_cnt;

    always #5 clk = ~clk;

    wb_pipe #(
        .D_SIZE       (32),
        .ADDR_LINE_REG(5),
        .CNT_W        (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .valid_f_mem          (valid_f_mem),
        .ready_f_wb_to_mem    (ready_f_wb_to_mem),
        .reg_write_f_mem      (reg_write_f_mem),
        .mem_to_reg_f_mem     (mem_to_reg_f_mem),
        .alu_out_f_mem_2_wb   (alu_out_f_mem_2_wb),
        .mem_rdata_f_mem_2_wb (mem_rdata_f_mem_2_wb),
        .ld_size_f_mem        (ld_size_f_mem),
        .ld_unsigned_f_mem    (ld_unsigned_f_mem),
        .ld_offset_f_mem      (ld_offset_f_mem),
        .alu_add_f_mem_2_wb   (alu_add_f_mem_2_wb),
        .flush_f_ctrl         (flush_f_ctrl),
        .rf_ready_f_id        (rf_ready_f_id),
        .wb_valid_f_wb_id     (wb_valid_f_wb_id),
        .reg_we_f_wb_id       (reg_we_f_wb_id),
        .reg_data_f_wb_id     (reg_data_f_wb_id),
        .reg_addr_f_wb_id     (reg_addr_f_wb_id),
        .mem_to_reg_f_wb_to_id(mem_to_reg_f_wb_to_id),
        .retire_cnt           (retire_cnt)
    );

    typedef struct {
        logic        we;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        m2r;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] exp_retire = 4'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a pop happens at the next edge whenever valid && rf_ready && !flush.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!wb_valid_f_wb_id) begin
                check("idle_zero",
                      {32'd0, reg_we_f_wb_id, reg_data_f_wb_id, mem_to_reg_f_wb_to_id},
                      64'd0);
                check("idle_addr", {59'd0, reg_addr_f_wb_id}, 64'd0);
            end else if (!rf_ready_f_id) begin
                check("stall_we", {63'd0, reg_we_f_wb_id}, 64'd0);
            end else if (!flush_f_ctrl) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wb_data", {32'd0, reg_data_f_wb_id}, {32'd0, e.data});
                    check("wb_addr", {59'd0, reg_addr_f_wb_id}, {59'd0, e.addr});
                    check("wb_we", {63'd0, reg_we_f_wb_id}, {63'd0, e.we});
                    check("wb_m2r", {63'd0, mem_to_reg_f_wb_to_id}, {63'd0, e.m2r});
                end
                exp_retire = exp_retire + 4'd1;
            end
        end
    end

    task automatic send(input logic rw, input logic m2r, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [1:0] size, input logic uns,
                        input logic [1:0] off, input logic [4:0] addr,
                        input logic [31:0] exp_data, input logic exp_accept);
        exp_t e;
        check("ready", {63'd0, ready_f_wb_to_mem}, {63'd0, exp_accept});
        valid_f_mem          = 1'b1;
        reg_write_f_mem      = rw;
        mem_to_reg_f_mem     = m2r;
        alu_out_f_mem_2_wb   = alu;
        mem_rdata_f_mem_2_wb = rdata;
        ld_size_f_mem        = size;
        ld_unsigned_f_mem    = uns;
        ld_offset_f_mem      = off;
        alu_add_f_mem_2_wb   = addr;
        if (exp_accept) begin
            e.we   = rw && (addr != 5'd0);
            e.data = exp_data;
            e.addr = addr;
            e.m2r  = m2r;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_f_mem = 1'b0;
    endtask

    task automatic alu_op(input logic rw, input logic [31:0] d, input logic [4:0] a,
                          input logic acc);
        send(rw, 1'b0, d, 32'hDEAD_BEEF, 2'b10, 1'b0, 2'd0, a, d, acc);
    endtask

    task automatic load(input logic [1:0] size, input logic uns, input logic [1:0] off,
                        input logic [31:0] exp_data);
        send(1'b1, 1'b1, 32'h5555_5555, 32'h80FF_7F01, size, uns, off, 5'd9, exp_data, 1'b1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !wb_valid_f_wb_id) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        rst_n                = 1'b0;
        valid_f_mem          = 1'b0;
        reg_write_f_mem      = 1'b0;
        mem_to_reg_f_mem     = 1'b0;
        alu_out_f_mem_2_wb   = '0;
        mem_rdata_f_mem_2_wb = '0;
        ld_size_f_mem        = '0;
        ld_unsigned_f_mem    = 1'b0;
        ld_offset_f_mem      = '0;
        alu_add_f_mem_2_wb   = '0;
        flush_f_ctrl         = 1'b0;
        rf_ready_f_id        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, ready_f_wb_to_mem}, 64'd1);
        check("rst_valid", {63'd0, wb_valid_f_wb_id}, 64'd0);
        check("rst_we", {63'd0, reg_we_f_wb_id}, 64'd0);
        check("rst_data", {32'd0, reg_data_f_wb_id}, 64'd0);
        check("rst_retire", {60'd0, retire_cnt}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ALU write-back.
        alu_op(1'b1, 32'h0000_1234, 5'd7, 1'b1);
        drain();
        check("retire_after_alu", {60'd0, retire_cnt}, 64'd1);

        // Load formatting of 0x80FF_7F01.
        load(2'b00, 1'b0, 2'd3, 32'hFFFF_FF80);
        load(2'b01, 1'b1, 2'd2, 32'h0000_80FF);
        load(2'b00, 1'b0, 2'd0, 32'h0000_0001);
        load(2'b00, 1'b1, 2'd1, 32'h0000_007F);
        load(2'b01, 1'b0, 2'd0, 32'h0000_7F01);
        load(2'b01, 1'b0, 2'd3, 32'hFFFF_80FF);
        load(2'b10, 1'b0, 2'd1, 32'h80FF_7F01);
        load(2'b11, 1'b1, 2'd0, 32'h80FF_7F01);
        drain();
        check("retire_after_loads", {60'd0, retire_cnt}, 64'd9);

        // Back-pressure: third entry refused, the first two retire in order.
        rf_ready_f_id = 1'b0;
        alu_op(1'b1, 32'h0000_0AAA, 5'd1, 1'b1);
        alu_op(1'b1, 32'h0000_0BBB, 5'd2, 1'b1);
        alu_op(1'b1, 32'h0000_0CCC, 5'd3, 1'b0);
        check("full_ready", {63'd0, ready_f_wb_to_mem}, 64'd0);
        rf_ready_f_id = 1'b1;
        drain();
        check("retire_after_bp", {60'd0, retire_cnt}, 64'd11);

        // Address 0 and non-writing entries still retire without a strobe.
        alu_op(1'b1, 32'h0000_00FF, 5'd0, 1'b1);
        alu_op(1'b0, 32'h0000_0077, 5'd5, 1'b1);
        drain();
        check("retire_after_x0", {60'd0, retire_cnt}, 64'd13);

        // Flush with two buffered and a new offer in the same cycle.
        rf_ready_f_id = 1'b0;
        alu_op(1'b1, 32'h1111_1111, 5'd4, 1'b1);
        alu_op(1'b1, 32'h2222_2222, 5'd6, 1'b1);
        flush_f_ctrl = 1'b1;
        valid_f_mem  = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        flush_f_ctrl = 1'b0;
        valid_f_mem  = 1'b0;
        check("flush_valid", {63'd0, wb_valid_f_wb_id}, 64'd0);
        check("flush_ready", {63'd0, ready_f_wb_to_mem}, 64'd1);
        check("flush_retire", {60'd0, retire_cnt}, 64'd13);
        rf_ready_f_id = 1'b1;
        @(posedge clk);
        #1;
        check("flush_dropped", {63'd0, wb_valid_f_wb_id}, 64'd0);

        // Asynchronous reset mid-operation.
        rf_ready_f_id = 1'b0;
        alu_op(1'b1, 32'h3333_3333, 5'd8, 1'b1);
        alu_op(1'b1, 32'h4444_4444, 5'd9, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_retire = 4'd0;
        check("mid_rst_valid", {63'd0, wb_valid_f_wb_id}, 64'd0);
        check("mid_rst_we", {63'd0, reg_we_f_wb_id}, 64'd0);
        check("mid_rst_ready", {63'd0, ready_f_wb_to_mem}, 64'd1);
        check("mid_rst_retire", {60'd0, retire_cnt}, 64'd0);
        rf_ready_f_id = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4-bit retire counter wraps: 17 retires read back as 1.
        for (int i = 0; i < 17; i++) alu_op(1'b1, 32'h100 + i, 5'd10 + 5'(i % 4), 1'b1);
        drain();
        check("retire_wrap", {60'd0, retire_cnt}, 64'd1);
        check("retire_model", {60'd0, retire_cnt}, {60'd0, exp_retire});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
